// File: rtl/rvfi_commit_sequencer_if.sv
// Handshake bundle between dispatch/execute/flush sources and the retirement
// sequencer, plus the retired-record stream toward the RVFI monitor.
interface rvfi_commit_sequencer_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned TAG_W = $clog2(DEPTH);
    localparam int unsigned REC_W = 311;

    logic             alloc_valid;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             cmp_valid;
    logic [TAG_W-1:0] cmp_tag;
    logic [REC_W-1:0] cmp_rec;
    logic             flush;
    logic             mon_valid;
    logic [63:0]      mon_order;
    logic [REC_W-1:0] mon_rec;
    logic             mon_halt;
    logic             err;

    modport master (
        output alloc_valid, cmp_valid, cmp_tag, cmp_rec, flush,
        input  alloc_ready, alloc_tag, mon_valid, mon_order, mon_rec, mon_halt, err
    );

    modport slave (
        input  alloc_valid, cmp_valid, cmp_tag, cmp_rec, flush,
        output alloc_ready, alloc_tag, mon_valid, mon_order, mon_rec, mon_halt, err
    );
endinterface

// File: rtl/rvfi_commit_sequencer.sv
// Retirement-side RVFI sequencer: tags allocated in program order, records
// completed in any order, retired strictly in order with a 64-bit order count.
module rvfi_commit_sequencer #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    rvfi_commit_sequencer_if.slave bus
);
    localparam int unsigned TAG_W = $clog2(DEPTH);
    localparam int unsigned REC_W = 311;
    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    logic [TAG_W-1:0] head_q;
    logic [TAG_W-1:0] tail_q;
    logic [TAG_W:0]   count_q;
    logic [63:0]      order_q;
    logic [DEPTH-1:0] alloc_q;
    logic [DEPTH-1:0] done_q;
    logic [REC_W-1:0] rec_q [DEPTH];

    logic             mon_valid_q;
    logic [63:0]      mon_order_q;
    logic [REC_W-1:0] mon_rec_q;
    logic             mon_halt_q;
    logic             err_q;

    logic             alloc_fire;
    logic             retire;
    logic             cmp_ok;
    logic             cmp_bad;
    logic [31:0]      head_inst;
    logic             halt_inst;

    // Readiness is taken from the registered count, so a full buffer refuses
    // allocation even in the cycle an entry retires.
    assign bus.alloc_ready = (count_q != FULL_CNT) && !mon_halt_q;
    assign bus.alloc_tag   = tail_q;
    assign bus.mon_valid   = mon_valid_q;
    assign bus.mon_order   = mon_order_q;
    assign bus.mon_rec     = mon_rec_q;
    assign bus.mon_halt    = mon_halt_q;
    assign bus.err         = err_q;

    always_comb begin
        alloc_fire = bus.alloc_valid && bus.alloc_ready;
        retire     = alloc_q[head_q] && done_q[head_q] && !mon_halt_q;
        cmp_ok     = bus.cmp_valid && alloc_q[bus.cmp_tag] && !done_q[bus.cmp_tag];
        cmp_bad    = bus.cmp_valid && !cmp_ok;
        head_inst  = rec_q[head_q][REC_W-1 -: 32];
        halt_inst  = head_inst inside {32'h0000_0063, 32'h0000_006f, 32'hF000_2013};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            order_q     <= '0;
            alloc_q     <= '0;
            done_q      <= '0;
            mon_valid_q <= 1'b0;
            mon_order_q <= '0;
            mon_rec_q   <= '0;
            mon_halt_q  <= 1'b0;
            err_q       <= 1'b0;
        end else if (bus.flush) begin
            alloc_q     <= '0;
            done_q      <= '0;
            tail_q      <= head_q;
            count_q     <= '0;
            mon_valid_q <= 1'b0;
        end else begin
            mon_valid_q <= retire;
            count_q     <= count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire);
            if (retire) begin
                mon_rec_q       <= rec_q[head_q];
                mon_order_q     <= order_q;
                order_q         <= order_q + 64'd1;
                head_q          <= head_q + TAG_W'(1);
                alloc_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
                if (halt_inst) begin
                    mon_halt_q <= 1'b1;
                end
            end
            // Head and tail only coincide with a live head entry when full,
            // and a full buffer never allocates, so these bit writes never collide.
            if (cmp_ok) begin
                done_q[bus.cmp_tag] <= 1'b1;
            end
            if (cmp_bad) begin
                err_q <= 1'b1;
            end
            if (alloc_fire) begin
                alloc_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                tail_q          <= tail_q + TAG_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !bus.flush && cmp_ok) begin
            rec_q[bus.cmp_tag] <= bus.cmp_rec;
        end
    end
endmodule

// File: tb/tb_rvfi_commit_sequencer.sv
// Scoreboard bench for rvfi_commit_sequencer: expected retirements are queued
// at allocation time and popped by a monitor process whenever mon_valid is seen.
module tb_rvfi_commit_sequencer;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TAG_W = $clog2(DEPTH);
    localparam int unsigned REC_W = 311;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] JAL_HALT = 32'h0000_006f;

    typedef struct {
        logic [63:0]      order;
        logic [REC_W-1:0] rec;
        logic             halt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   mon_count = 0;
    int   mon_cyc [64];
    exp_t exp_q [$];
    logic [REC_W-1:0] rec_of_tag [DEPTH];
    logic [TAG_W-1:0] model_tail = '0;
    logic [63:0]      exp_order = '0;

    rvfi_commit_sequencer_if #(.DEPTH(DEPTH)) bus ();
    rvfi_commit_sequencer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [REC_W-1:0] make_rec(input logic [31:0] inst, input logic [31:0] pc);
        return {inst, pc, pc + 32'd4, 5'd1, 5'd2, pc ^ 32'h1111_1111, pc ^ 32'h2222_2222,
                5'd3, pc ^ 32'h3333_3333, pc ^ 32'h4444_4444, 4'hf, 4'h0,
                pc ^ 32'h5555_5555, pc ^ 32'h6666_6666};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_rec(input string name, input logic [REC_W-1:0] act, input logic [REC_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.mon_valid) begin
                mon_count++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_retire: got order %0d, required no retire", bus.mon_order);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_order", bus.mon_order, e.order);
                    check_rec("mon_rec", bus.mon_rec, e.rec);
                    check("mon_halt", 64'(bus.mon_halt), 64'(e.halt));
                    mon_cyc[e.order[5:0]] = cyc;
                end
            end
        end
    endtask

    task automatic alloc_one(input logic [31:0] inst, input bit emit, input bit halt);
        exp_t e;
        check("alloc_ready", 64'(bus.alloc_ready), 64'd1);
        check("alloc_tag", 64'(bus.alloc_tag), 64'(model_tail));
        rec_of_tag[model_tail] = make_rec(inst, emit ? 32'h8000_0000 + 32'(exp_order) * 32'd4
                                                     : 32'h9000_0000 + 32'(cyc));
        if (emit) begin
            e.order = exp_order;
            e.rec   = rec_of_tag[model_tail];
            e.halt  = halt;
            exp_q.push_back(e);
            exp_order++;
        end
        bus.alloc_valid = 1'b1;
        step();
        bus.alloc_valid = 1'b0;
        model_tail++;
    endtask

    task automatic complete(input logic [TAG_W-1:0] tag, output int edge_cyc);
        bus.cmp_valid = 1'b1;
        bus.cmp_tag   = tag;
        bus.cmp_rec   = rec_of_tag[tag];
        step();
        bus.cmp_valid = 1'b0;
        edge_cyc = cyc;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        step();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mon_valid"}, 64'(bus.mon_valid), 64'd0);
        check({tag, "_mon_halt"}, 64'(bus.mon_halt), 64'd0);
        check({tag, "_err"}, 64'(bus.err), 64'd0);
        check({tag, "_mon_order"}, bus.mon_order, 64'd0);
        check_rec({tag, "_mon_rec"}, bus.mon_rec, '0);
        check({tag, "_alloc_ready"}, 64'(bus.alloc_ready), 64'd1);
        check({tag, "_alloc_tag"}, 64'(bus.alloc_tag), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int e0, e1, e2, n, snap;
        bus.alloc_valid = 1'b0;
        bus.cmp_valid   = 1'b0;
        bus.cmp_tag     = '0;
        bus.cmp_rec     = '0;
        bus.flush       = 1'b0;
        fork
            monitor();
        join_none

        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        check_idle_outputs("reset");

        // In-order flow: three consecutive retirements one cycle after each completion.
        for (int i = 0; i < 3; i++) alloc_one(NOP, 1'b1, 1'b0);
        complete(0, e0);
        complete(1, e1);
        complete(2, e2);
        drain("inorder_drain");
        check("inorder_lat0", 64'(mon_cyc[0]), 64'(e0 + 1));
        check("inorder_lat1", 64'(mon_cyc[1]), 64'(mon_cyc[0] + 1));
        check("inorder_lat2", 64'(mon_cyc[2]), 64'(mon_cyc[1] + 1));

        // Out-of-order: tags 3..6, completed youngest first, head last.
        for (int i = 0; i < 4; i++) alloc_one(NOP, 1'b1, 1'b0);
        snap = mon_count;
        complete(6, n);
        complete(5, n);
        complete(4, n);
        idle(2);
        check("ooo_no_early_retire", 64'(mon_count), 64'(snap));
        complete(3, n);
        check("ooo_no_retire_at_n", 64'(mon_count), 64'(snap));
        drain("ooo_drain");
        check("ooo_first_lat", 64'(mon_cyc[3]), 64'(n + 1));
        check("ooo_last_lat", 64'(mon_cyc[6]), 64'(n + 4));

        // Halt at order 7; younger completed entries stay parked.
        alloc_one(JAL_HALT, 1'b1, 1'b1);
        alloc_one(NOP, 1'b0, 1'b0);
        alloc_one(NOP, 1'b0, 1'b0);
        complete(0, n);
        complete(7, n);
        drain("halt_drain");
        check("halt_sticky", 64'(bus.mon_halt), 64'd1);
        check("halt_alloc_ready", 64'(bus.alloc_ready), 64'd0);
        complete(1, n);
        check("halt_cmp_no_err", 64'(bus.err), 64'd0);
        snap = mon_count;
        idle(5);
        check("halt_no_more_retire", 64'(mon_count), 64'(snap));

        // Error: tag 4 is not allocated.
        complete(4, n);
        check("err_set", 64'(bus.err), 64'd1);
        idle(2);
        check("err_sticky", 64'(bus.err), 64'd1);

        // Mid-stream reset with tags 0 and 1 still outstanding.
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_idle_outputs("midreset");
        model_tail = '0;
        exp_order  = '0;

        // Full buffer: eighth alloc fills it, refused while full even on the retire cycle.
        for (int i = 0; i < 8; i++) alloc_one(NOP, 1'b1, 1'b0);
        check("full_alloc_ready", 64'(bus.alloc_ready), 64'd0);
        bus.alloc_valid = 1'b1;
        complete(0, n);
        check("full_refused_tag", 64'(bus.alloc_tag), 64'd0);
        check("full_still_not_ready", 64'(bus.alloc_ready), 64'd0);
        step();
        check("full_retire_refused_tag", 64'(bus.alloc_tag), 64'd0);
        check("full_ready_after_retire", 64'(bus.alloc_ready), 64'd1);
        bus.alloc_valid = 1'b0;
        alloc_one(NOP, 1'b1, 1'b0);
        check("wrap_tail_next", 64'(bus.alloc_tag), 64'd1);
        for (int t = 1; t < 8; t++) complete(TAG_W'(t), n);
        complete(0, n);
        drain("full_drain");

        // Flush on the cycle tag 1 would retire; order resumes at 9 from head tag 1.
        for (int i = 0; i < 5; i++) alloc_one(NOP, 1'b1, 1'b0);
        complete(1, n);
        bus.flush     = 1'b1;
        bus.cmp_valid = 1'b1;
        bus.cmp_tag   = 2;
        bus.cmp_rec   = rec_of_tag[2];
        step();
        bus.flush     = 1'b0;
        bus.cmp_valid = 1'b0;
        repeat (5) void'(exp_q.pop_back());
        exp_order  = 64'd9;
        model_tail = 1;
        snap = mon_count;
        idle(4);
        check("flush_no_retire", 64'(mon_count), 64'(snap));
        check("flush_alloc_tag", 64'(bus.alloc_tag), 64'd1);
        check("flush_alloc_ready", 64'(bus.alloc_ready), 64'd1);
        alloc_one(NOP, 1'b1, 1'b0);
        complete(1, n);
        drain("flush_resume_drain");
        check("flush_err_clear", 64'(bus.err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
